// File: rtl/uart_imem_loader.sv
// Boot loader: 8N1 UART receiver feeding a length-prefixed little-endian image into instruction memory.
// Latency: imem_we one cycle after the 4th byte of a word; no backpressure (the serial line cannot stall).
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PC_WIDTH     = 12,
    parameter int OP_LENGTH    = 32
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 imem_we,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic [OP_LENGTH-1:0] imem_wdata,
    output logic                 cpu_rst,
    output logic                 loading,
    output logic                 load_err
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [32:0]   MAX_WORDS = 33'd1 << PC_WIDTH;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_LEN_LO, WAIT_LEN_HI, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

    logic          rx_meta;
    logic          rx_sync;
    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_shift;
    logic          half_tick;
    logic          bit_tick;
    logic          byte_valid;
    logic          frame_err;

    ld_state_t              ld_state;
    ld_state_t              ld_next;
    logic [15:0]            word_len;
    logic [15:0]            word_cnt;
    logic [15:0]            hdr_len;
    logic [1:0]             byte_cnt;
    logic [OP_LENGTH-9:0]   word_acc;
    logic                   last_word;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        half_tick  = (rx_state == RX_START) && (clk_cnt == HALF_END);
        bit_tick   = (clk_cnt == BIT_END);
        byte_valid = (rx_state == RX_STOP) && bit_tick && rx_sync;
        frame_err  = (rx_state == RX_STOP) && bit_tick && !rx_sync;
    end

    // The bit timer restarts at mid-start-bit so every later sample lands mid-bit.
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || half_tick || bit_tick) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (rx_state == RX_START) begin
                bit_cnt <= '0;
            end
            if (rx_state == RX_DATA && bit_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                bit_cnt  <= bit_cnt + 1'b1;
            end
        end
    end

    assign hdr_len   = {rx_shift, word_len[7:0]};
    assign last_word = (word_cnt + 16'd1) == word_len;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            ld_state <= WAIT_LEN_LO;
        end else begin
            ld_state <= ld_next;
        end
    end

    // DONE deliberately ignores framing errors: the CPU is already running.
    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            WAIT_LEN_LO: begin
                if (frame_err) ld_next = LD_ERR;
                else if (byte_valid) ld_next = WAIT_LEN_HI;
            end
            WAIT_LEN_HI: begin
                if (frame_err) begin
                    ld_next = LD_ERR;
                end else if (byte_valid) begin
                    if (hdr_len == 16'd0) ld_next = LD_DONE;
                    else if ({17'd0, hdr_len} > MAX_WORDS) ld_next = LD_ERR;
                    else ld_next = LD_DATA;
                end
            end
            LD_DATA: begin
                if (frame_err) ld_next = LD_ERR;
                else if (imem_we && last_word) ld_next = LD_DONE;
            end
            LD_DONE:  ld_next = LD_DONE;
            LD_ERR:   ld_next = LD_ERR;
            default:  ld_next = LD_ERR;
        endcase
    end

    always_comb begin
        cpu_rst  = (ld_state != LD_DONE);
        loading  = (ld_state == WAIT_LEN_HI) || (ld_state == LD_DATA);
        load_err = (ld_state == LD_ERR);
    end

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_len   <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            word_acc   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) begin
                imem_addr <= imem_addr + 1'b1;
                word_cnt  <= word_cnt + 16'd1;
            end
            if (byte_valid) begin
                case (ld_state)
                    WAIT_LEN_LO: word_len[7:0]  <= rx_shift;
                    WAIT_LEN_HI: word_len[15:8] <= rx_shift;
                    LD_DATA: begin
                        word_acc <= {rx_shift, word_acc[OP_LENGTH-9:8]};
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {rx_shift, word_acc};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboarded bench: images are serialised onto uart_rx, expected writes queued up front,
// and a monitor pops and compares every imem_we strobe.
module tb_uart_imem_loader;
    localparam int CPB = 8;
    localparam int PCW = 4;

    logic            sysclk  = 1'b0;
    logic            rst     = 1'b0;
    logic            uart_rx = 1'b1;
    logic            imem_we;
    logic [PCW-1:0]  imem_addr;
    logic [31:0]     imem_wdata;
    logic            cpu_rst;
    logic            loading;
    logic            load_err;

    typedef struct packed {
        logic [PCW-1:0] addr;
        logic [31:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_we_cyc = -1;
    int  fall_cyc = -1;
    logic prev_cpu_rst = 1'b1;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .PC_WIDTH    (PCW),
        .OP_LENGTH   (32)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst   (cpu_rst),
        .loading   (loading),
        .load_err  (load_err)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        wr_t got;
        wr_t want;
        if (imem_we === 1'b1) begin
            got = '{addr: imem_addr, data: imem_wdata};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", imem_addr, imem_wdata);
            end else begin
                want = exp_q.pop_front();
                if (got !== want || cpu_rst !== 1'b1) begin
                    errors++;
                    $display("FAIL imem_write: got addr=%0d data=%08h cpu_rst=%b, required addr=%0d data=%08h cpu_rst=1",
                             imem_addr, imem_wdata, cpu_rst, want.addr, want.data);
                end
            end
            last_we_cyc = cyc;
        end
        if (prev_cpu_rst === 1'b1 && cpu_rst === 1'b0) fall_cyc = cyc;
        prev_cpu_rst = cpu_rst;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        tick(2);
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b0;
        uart_rx = 1'b1;
        tick(3);
        if (chk) begin
            check("rst_imem_we", imem_we, 0);
            check("rst_imem_addr", imem_addr, 0);
            check("rst_imem_wdata", imem_wdata, 0);
            check("rst_cpu_rst", cpu_rst, 1);
            check("rst_loading", loading, 0);
            check("rst_load_err", load_err, 0);
        end
        exp_q.delete();
        last_we_cyc = -1;
        fall_cyc = -1;
        rst = 1'b1;
        tick(1);
    endtask

    // Reference: a well-formed image of N words (1..2^PCW) writes word i to address i.
    task automatic send_image(input logic [15:0] n, input logic [31:0] words[$]);
        if (n != 0 && int'(n) <= (1 << PCW)) begin
            for (int i = 0; i < int'(n); i++) exp_q.push_back('{addr: PCW'(i), data: words[i]});
        end
        send_byte(n[7:0], 1'b1);
        check("loading_after_len_lo", loading, 1);
        send_byte(n[15:8], 1'b1);
        foreach (words[i]) begin
            for (int b = 0; b < 4; b++) send_byte(words[i][8*b +: 8], 1'b1);
        end
    endtask

    task automatic finish_ok(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        tick(4);
        check({name, "_cpu_rst"}, cpu_rst, 0);
        check({name, "_loading"}, loading, 0);
        check({name, "_load_err"}, load_err, 0);
        check({name, "_release_delay"}, fall_cyc - last_we_cyc, 1);
    endtask

    initial begin
        logic [31:0] w[$];
        int n;

        do_reset(1'b1);

        w = '{32'h00100513, 32'h00200593};
        send_image(16'd2, w);
        finish_ok("two_words");

        do_reset(1'b0);
        w = '{};
        send_image(16'd0, w);
        tick(4);
        check("empty_cpu_rst", cpu_rst, 0);
        check("empty_load_err", load_err, 0);
        check("empty_loading", loading, 0);
        check("empty_no_write", last_we_cyc, -1);

        do_reset(1'b0);
        w = '{$urandom()};
        send_image(16'h0011, w);
        tick(4);
        check("toolong_load_err", load_err, 1);
        check("toolong_cpu_rst", cpu_rst, 1);
        check("toolong_loading", loading, 0);
        check("toolong_no_write", last_we_cyc, -1);

        do_reset(1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b0);
        tick(CPB * 2);
        send_byte(8'h13, 1'b1);
        tick(4);
        check("frame_load_err", load_err, 1);
        check("frame_cpu_rst", cpu_rst, 1);
        check("frame_loading", loading, 0);
        do_reset(1'b0);
        check("frame_cleared", load_err, 0);
        w = '{$urandom()};
        send_image(16'd1, w);
        finish_ok("after_frame_err");

        do_reset(1'b0);
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(CPB * 4);
        check("glitch_loading", loading, 0);
        check("glitch_cpu_rst", cpu_rst, 1);
        w = '{};
        for (int i = 0; i < 16; i++) w.push_back($urandom());
        send_image(16'd16, w);
        finish_ok("full_16");

        do_reset(1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        do_reset(1'b1);
        w = '{32'hDDCCBBAA};
        send_image(16'd1, w);
        finish_ok("after_mid_reset");

        for (int k = 0; k < 4; k++) begin
            do_reset(1'b0);
            n = $urandom_range(1, 6);
            w = '{};
            for (int i = 0; i < n; i++) w.push_back($urandom());
            send_image(16'(n), w);
            finish_ok("random_image");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
